// File: rtl/fir_mac_seq_pkg.sv
// rtl/fir_mac_seq_pkg.sv - state encodings and datapath widths shared by the FIR MAC sequencer
package fir_mac_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_MAC   = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   localparam int DW     = 18;
   localparam int AW     = 7;
   localparam int PROD_W = 36;
   localparam int ACC_W  = 43;

endpackage

// File: rtl/fir_mac_seq_mac.sv
// rtl/fir_mac_seq_mac.sv - three-stage multiply-accumulate with rounding preload and saturating output
// a_in is captured combinationally-fresh; b_in arrives one cycle later from a registered memory.
module mac18x18_acc
   import fir_mac_seq_pkg::*;
#(
   parameter int OW    = 24,
   parameter int SHIFT = 17
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 preload,
   input  logic                 in_vld,
   input  logic signed [DW-1:0] a_in,
   input  logic signed [DW-1:0] b_in,
   input  logic                 out_ld,
   output logic signed [OW-1:0] dout
);

   localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1) << (SHIFT - 1);
   localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) << (OW - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

   logic signed [DW-1:0]     a_q, a_d;
   logic                     v1_q, v1_d;
   logic signed [PROD_W-1:0] prod_q, prod_d;
   logic                     v2_q, v2_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [OW-1:0]     dout_q, dout_d;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  shifted;

   always_comb begin
      a_d      = in_vld ? a_in : a_q;
      v1_d     = in_vld;
      prod_d   = v1_q ? a_q * b_in : prod_q;
      v2_d     = v1_q;
      prod_ext = $signed({{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q});
      if (preload) begin
         acc_d = ROUND;
      end else if (v2_q) begin
         acc_d = acc_q + prod_ext;
      end else begin
         acc_d = acc_q;
      end
      // Output is taken from the next accumulator value so the last product lands in the same edge.
      shifted = acc_d >>> SHIFT;
      dout_d  = dout_q;
      if (out_ld) begin
         if (shifted > MAX_V) begin
            dout_d = MAX_V[OW-1:0];
         end else if (shifted < MIN_V) begin
            dout_d = MIN_V[OW-1:0];
         end else begin
            dout_d = shifted[OW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         v1_q   <= 1'b0;
         prod_q <= '0;
         v2_q   <= 1'b0;
         acc_q  <= '0;
         dout_q <= '0;
      end else begin
         a_q    <= a_d;
         v1_q   <= v1_d;
         prod_q <= prod_d;
         v2_q   <= v2_d;
         acc_q  <= acc_d;
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - FIR tap sequencer: shifts samples into the delay line and walks taps through the MAC
// Owns all delay-line control; delay line and coefficient memory live in the parent.
module fir_mac_seq
   import fir_mac_seq_pkg::*;
#(
   parameter int TAPS  = 128,
   parameter int OW    = 24,
   parameter int SHIFT = 17
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [17:0]   din,
   input  logic          din_stb,
   output logic          ready,
   output logic [17:0]   srl_d,
   output logic          srl_ce,
   output logic [6:0]    srl_a,
   input  logic [17:0]   srl_y,
   output logic [6:0]    coef_a,
   input  logic [17:0]   coef,
   output logic [OW-1:0] dout,
   output logic          dout_stb,
   output logic          overrun
);

   localparam logic [AW-1:0] LAST_K = AW'(TAPS - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] k_q, k_d;
   logic          flush_q, flush_d;
   logic [DW-1:0] srl_d_q, srl_d_d;
   logic          dout_stb_q, dout_stb_d;
   logic          overrun_q, overrun_d;
   logic          preload;
   logic          mac_vld;
   logic          out_ld;

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      flush_d    = flush_q;
      srl_d_d    = srl_d_q;
      dout_stb_d = 1'b0;
      overrun_d  = overrun_q | (din_stb & (state_q != ST_IDLE));
      preload    = 1'b0;
      mac_vld    = 1'b0;
      out_ld     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (din_stb) begin
               srl_d_d = din;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            preload = 1'b1;
            k_d     = '0;
            state_d = ST_MAC;
         end
         ST_MAC: begin
            mac_vld = 1'b1;
            if (k_q == LAST_K) begin
               k_d     = '0;
               flush_d = 1'b0;
               state_d = ST_FLUSH;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         ST_FLUSH: begin
            // Two cycles cover the product and accumulate stages behind the last address.
            flush_d = 1'b1;
            if (flush_q) begin
               flush_d    = 1'b0;
               out_ld     = 1'b1;
               dout_stb_d = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         k_q        <= '0;
         flush_q    <= 1'b0;
         srl_d_q    <= '0;
         dout_stb_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         flush_q    <= flush_d;
         srl_d_q    <= srl_d_d;
         dout_stb_q <= dout_stb_d;
         overrun_q  <= overrun_d;
      end
   end

   mac18x18_acc #(
      .OW    (OW),
      .SHIFT (SHIFT)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .preload (preload),
      .in_vld  (mac_vld),
      .a_in    ($signed(srl_y)),
      .b_in    ($signed(coef)),
      .out_ld  (out_ld),
      .dout    (dout)
   );

   assign ready    = (state_q == ST_IDLE);
   assign srl_ce   = (state_q == ST_LOAD);
   assign srl_d    = srl_d_q;
   assign srl_a    = k_q;
   assign coef_a   = k_q;
   assign dout_stb = dout_stb_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb/tb_fir_mac_seq.sv - self-checking bench for fir_mac_seq with delay-line and coefficient memory models
module tb_fir_mac_seq;

   localparam int TAPS  = 128;
   localparam int OW    = 24;
   localparam int SHIFT = 17;
   localparam longint SAT_MAX = (longint'(1) << (OW - 1)) - 1;
   localparam longint SAT_MIN = -(longint'(1) << (OW - 1));

   typedef struct {
      logic [17:0] din;
      longint      exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [17:0]   din;
   logic          din_stb;
   logic          ready;
   logic [17:0]   srl_d;
   logic          srl_ce;
   logic [6:0]    srl_a;
   logic [17:0]   srl_y;
   logic [6:0]    coef_a;
   logic [17:0]   coef;
   logic [OW-1:0] dout;
   logic          dout_stb;
   logic          overrun;

   logic [17:0] srl_mem [128] = '{default: '0};
   logic [17:0] coef_mem [128];
   logic [17:0] hist [$];
   int n_chk  = 0;
   int n_fail = 0;

   fir_mac_seq #(.TAPS(TAPS), .OW(OW), .SHIFT(SHIFT)) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .din_stb  (din_stb),
      .ready    (ready),
      .srl_d    (srl_d),
      .srl_ce   (srl_ce),
      .srl_a    (srl_a),
      .srl_y    (srl_y),
      .coef_a   (coef_a),
      .coef     (coef),
      .dout     (dout),
      .dout_stb (dout_stb),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (srl_ce) begin
         for (int i = 127; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
         srl_mem[0] <= srl_d;
      end
   end
   assign srl_y = srl_mem[srl_a];

   always @(posedge clk) coef <= coef_mem[coef_a];

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference: direct convolution of the sample history with the coefficient table.
   function automatic longint ref_out();
      longint acc = longint'(1) << (SHIFT - 1);
      for (int k = 0; k < TAPS; k++)
         acc += longint'($signed(hist[k])) * longint'($signed(coef_mem[k]));
      acc = acc >>> SHIFT;
      if (acc > SAT_MAX) return SAT_MAX;
      if (acc < SAT_MIN) return SAT_MIN;
      return acc;
   endfunction

   task automatic accept(input logic [17:0] x);
      hist.push_front(x);
      hist.delete(hist.size() - 1);
   endtask

   task automatic wait_dout(inout int n);
      while (!dout_stb && n < TAPS + 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic send(input logic [17:0] x, output longint got);
      longint exp;
      int n;
      accept(x);
      exp = ref_out();
      din = x;
      din_stb = 1'b1;
      @(posedge clk); #1;
      din_stb = 1'b0;
      din = '0;
      check("busy_after_accept", ready, 0);
      n = 1;
      wait_dout(n);
      check("latency", n, TAPS + 4);
      got = longint'($signed(dout));
      check("dout_vs_model", got, exp);
      check("ready_at_dout", ready, 1);
   endtask

   initial begin
      vec_t tbl [8];
      longint got, exp;
      logic [17:0] a;
      int n, stb_cnt;

      for (int i = 0; i < 128; i++) hist.push_back('0);
      tbl[0] = '{18'h10000, 0};
      tbl[1] = '{18'h00000, 1};
      tbl[2] = '{18'h00000, 2};
      tbl[3] = '{18'h08000, 3};
      tbl[4] = '{18'h00000, 5};
      tbl[5] = '{18'h30000, 6};
      tbl[6] = '{18'h00000, 7};
      tbl[7] = '{18'h00000, 7};

      rst = 1'b1;
      din = '0;
      din_stb = 1'b0;
      for (int k = 0; k < 128; k++) coef_mem[k] = 18'(2 * k);
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready, 1);
      check("rst_srl_ce", srl_ce, 0);
      check("rst_dout_stb", dout_stb, 0);
      check("rst_overrun", overrun, 0);
      check("rst_dout", dout, 0);
      check("rst_srl_d", srl_d, 0);
      check("rst_srl_a", srl_a, 0);
      check("rst_coef_a", coef_a, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Impulse response with h[k]=2k; back-to-back samples also exercise minimum sample period.
      send(18'h10000, got);
      check("impulse_n0", got, 0);
      for (int i = 1; i <= 128; i++) begin
         send(18'h00000, got);
         check("impulse", got, (i == 128) ? 0 : i);
      end

      for (int i = 0; i < 8; i++) begin
         send(tbl[i].din, got);
         check("table_vec", got, tbl[i].exp);
      end

      for (int k = 0; k < 128; k++) coef_mem[k] = 18'h1FFFF;
      for (int i = 0; i < 128; i++) send(18'h1FFFF, got);
      check("sat_pos", got, SAT_MAX);
      for (int i = 0; i < 128; i++) send(18'h20000, got);
      check("sat_neg", got, SAT_MIN);

      for (int k = 0; k < 128; k++) coef_mem[k] = 18'($urandom_range(0, 2047)) - 18'd1024;
      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         send(18'($urandom), got);
      end
      check("no_overrun_after_stream", overrun, 0);

      // Second strobe at cycle 5 must be dropped without disturbing the result.
      a = 18'($urandom);
      accept(a);
      exp = ref_out();
      din = a;
      din_stb = 1'b1;
      @(posedge clk); #1;
      din_stb = 1'b0;
      n = 1;
      while (n < 5) begin
         @(posedge clk); #1;
         n++;
      end
      check("ovr_ready_c5", ready, 0);
      din = ~a;
      din_stb = 1'b1;
      @(posedge clk); #1;
      din_stb = 1'b0;
      din = '0;
      n++;
      check("ovr_set", overrun, 1);
      wait_dout(n);
      check("ovr_latency", n, TAPS + 4);
      check("ovr_dout", longint'($signed(dout)), exp);
      send(18'($urandom), got);
      check("ovr_sticky", overrun, 1);

      // Reset at cycle 40 of a computation; the sample already sits in the delay line.
      a = 18'h0ABCD;
      accept(a);
      din = a;
      din_stb = 1'b1;
      @(posedge clk); #1;
      din_stb = 1'b0;
      din = '0;
      n = 1;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("pre_rst_busy", ready, 0);
      #3;
      rst = 1'b1;
      #1;
      check("arst_ready", ready, 1);
      check("arst_srl_ce", srl_ce, 0);
      check("arst_dout_stb", dout_stb, 0);
      check("arst_overrun", overrun, 0);
      check("arst_dout", dout, 0);
      check("arst_srl_d", srl_d, 0);
      check("arst_srl_a", srl_a, 0);
      check("arst_coef_a", coef_a, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      stb_cnt = 0;
      for (int i = 0; i < TAPS + 10; i++) begin
         @(posedge clk); #1;
         if (dout_stb) stb_cnt++;
      end
      check("no_stb_after_rst", stb_cnt, 0);
      send(18'($urandom), got);
      send(18'($urandom), got);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_mac_seq.md
# fir_mac_seq

Sequencer and multiply-accumulate engine for a 128-tap, 18-bit FIR filter built on the srl128x18e addressable delay line.

- On each input sample strobe, it shifts the sample into the delay line.
- It then walks the delay-line address and a coefficient-memory address in lockstep through `TAPS` products.
- It rounds and saturates the accumulated sum, then emits one output sample with a strobe.
- It sits between the sample source (decimator/mixer) and the downstream output stage, and owns all `srl_*` control.

## Interface
- `TAPS`, 128: taps evaluated per output, 2..128.
- `OW`, 24: output width, signed.
- `SHIFT`, 17: right shift applied to the accumulator before saturation; must be at least 1.

- `clk`  in  1  clock; all logic rises on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  18  input sample, signed two's complement.
- `din_stb`  in  1  one-cycle sample-valid strobe.
- `ready`  out  1  high when a `din_stb` will be accepted (state IDLE).
- `srl_d`  out  18  delay-line data input.
- `srl_ce`  out  1  delay-line shift enable.
- `srl_a`  out  7  delay-line tap address; 0 is the newest sample.
- `srl_y`  in  18  delay-line output; combinational from `srl_a`.
- `coef_a`  out  7  coefficient address.
- `coef`  in  18  coefficient h[`coef_a`], signed; synchronous memory, valid 1 cycle after the address.
- `dout`  out  `OW`  filtered sample, signed.
- `dout_stb`  out  1  one-cycle output-valid strobe.
- `overrun`  out  1  sticky; set when `din_stb` arrives while `ready`=0.

## Operation
**States:** IDLE → LOAD → MAC → FLUSH → IDLE.
- **IDLE:** `ready`=1. On `din_stb`, register `din` into `srl_d` and go to LOAD.
- **LOAD:** one cycle with `srl_ce`=1; the delay line shifts at the end of the cycle. Clear `k`, preload the accumulator with the rounding constant 1<<(`SHIFT`-1), go to MAC.
- **MAC:** `TAPS` cycles.
  - `srl_a`=`coef_a`=`k`; `k` increments each cycle.
  - Leave for FLUSH after `k`=`TAPS`-1.
- **FLUSH:** 2 cycles to drain the pipeline, then return to IDLE.
  - On FLUSH exit, `dout` is loaded and `dout_stb` is pulsed.

**MAC pipeline:**
- S1 registers `srl_y` and `coef` (both aligned to the address of the previous cycle).
- S2 registers the signed 36-bit product.
- S3 adds it into a 43-bit signed accumulator.

**Output arithmetic:**
- `dout` = saturate(acc >>> `SHIFT`) to `OW` bits signed.
- Saturation clamps to 2^(OW-1)-1 or -2^(OW-1). There is no wrap-around.
- Rounding is round-half-up via the accumulator preload.

**Boundary conditions:**
- **Overrun:** `din_stb` while `ready`=0 drops the sample and sets `overrun`. The filter state and the in-flight output are unaffected. `overrun` clears only on `rst`.
- **`din_stb` in the same cycle `dout_stb` fires:** accepted, because the state is already IDLE.
- **Reset values:**
  - state IDLE; `ready`=1.
  - `srl_ce`=0, `dout_stb`=0, `overrun`=0.
  - `dout`=0, `srl_d`=0, `srl_a`=0, `coef_a`=0; accumulator 0.
- **Reset mid-operation:** the result is abandoned and no `dout_stb` is generated. Delay-line contents are not cleared (the SRLs have no reset), so stale history remains.

## Timing
- `din_stb` accepted in cycle 0.
- Cycle 1: LOAD.
- Cycles 2..`TAPS`+1: MAC.
- Cycles `TAPS`+2..`TAPS`+3: FLUSH.
- Cycle `TAPS`+4: `dout` valid, `dout_stb`=1, `ready`=1.
- Latency is `TAPS`+4 cycles. The minimum sample period is `TAPS`+4 (132 at `TAPS`=128).
- `srl_a`/`coef_a` change only on clock edges. `srl_y` must settle within one cycle of the address.

## Structure
- A shared include file holds the state encodings (IDLE=0, LOAD=1, MAC=2, FLUSH=3), the product width (36) and the accumulator width (43).
- One sub-module, `mac18x18_acc`, contains the three-stage registered multiply-accumulate with preload and saturating output. The FSM and address counter stay in `fir_mac_seq`.
- The srl128x18e instance and the coefficient memory are instantiated by the parent, not inside this block.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs at their reset values immediately, `ready`=1.
- **Impulse response:** h[k]=2k, `TAPS`=128, `SHIFT`=17; `din`=0x10000, then 128 zeros → outputs n=0..127 equal n. The 129th output is 0.
- **Saturation:** all h=0x1FFFF.
  - 128 samples of 0x1FFFF → `dout`=0x7FFFFF.
  - 128 samples of 0x20000 → `dout`=0x800000.
- **Overrun:** second `din_stb` at cycle 5 → `overrun`=1, sample dropped, the first result is unchanged, `ready` follows the normal schedule.
- **Throughput:** `TAPS`=16, `din_stb` every 20 cycles → each `dout_stb` exactly 20 cycles after its `din_stb`, no overrun.
- **Reset mid-MAC:** `rst` in cycle 40 → no `dout_stb`; after release, the next `din_stb` is accepted and produces a result after `TAPS`+4 cycles.
